// File: rtl/decode_forward_unit.sv
// Decode-stage forwarding and hazard unit: tracks in-flight destination tags and
// resolves NUM_SRC decode operands against later-stage results, stalling when needed.
module decode_forward_unit #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_W-1:0]  id_src,
    input  logic [NUM_SRC*DATA_W-1:0] id_rd_data,
    input  logic [REG_W-1:0]          id_dest,
    input  logic                      id_regwrite,
    input  logic                      id_is_load,
    input  logic [DEPTH*DATA_W-1:0]   stage_data,
    input  logic                      flush,
    output logic [NUM_SRC*DATA_W-1:0] fwd_data,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_cnt
);

    logic [DEPTH-1:0] tag_valid_reg;
    logic [DEPTH-1:0] tag_regwrite_reg;
    logic [DEPTH-1:0] tag_load_reg;
    logic [REG_W-1:0] tag_dest_reg [DEPTH];
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;
    logic [NUM_SRC-1:0] op_stall;
    logic entry_load;
    logic unused_bits;

    // Slice 0 of stage_data is never a source, and only entry 1's load flag matters.
    assign unused_bits = ^{stage_data[DATA_W-1:0], tag_load_reg};

    genvar gi, gk;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_op
            logic [REG_W-1:0]  src;
            logic [DEPTH-1:0]  hit;
            logic [DATA_W-1:0] data_next;
            logic [1:0]        sel_next;
            logic              stall_next;

            assign src = id_src[gi*REG_W +: REG_W];

            for (gk = 0; gk < DEPTH; gk++) begin : g_hit
                assign hit[gk] = tag_valid_reg[gk] && tag_regwrite_reg[gk] &&
                                 (tag_dest_reg[gk] == src) && (src != '0);
            end

            // Scan oldest to youngest so the youngest match overrides.
            always_comb begin
                data_next  = id_rd_data[gi*DATA_W +: DATA_W];
                sel_next   = 2'd0;
                stall_next = 1'b0;
                for (int k = DEPTH - 1; k >= 1; k--) begin
                    if (hit[k]) begin
                        if (k == 1 && tag_load_reg[1]) begin
                            stall_next = 1'b1;
                            sel_next   = 2'd3;
                            data_next  = id_rd_data[gi*DATA_W +: DATA_W];
                        end else begin
                            stall_next = 1'b0;
                            sel_next   = (k == 1) ? 2'd1 : 2'd2;
                            data_next  = stage_data[k*DATA_W +: DATA_W];
                        end
                    end
                end
                if (hit[0]) begin
                    stall_next = 1'b1;
                    sel_next   = 2'd3;
                    data_next  = id_rd_data[gi*DATA_W +: DATA_W];
                end
            end

            assign fwd_data[gi*DATA_W +: DATA_W] = data_next;
            assign fwd_sel[gi*2 +: 2]            = sel_next;
            assign op_stall[gi]                  = stall_next;
        end
    endgenerate

    assign stall      = id_valid && (|op_stall);
    assign entry_load = id_valid && !stall && !flush;
    assign stall_cnt  = stall_cnt_reg;

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stall && (stall_cnt_reg != {CNT_W{1'b1}}))
            stall_cnt_next = stall_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tag_valid_reg    <= '0;
            tag_regwrite_reg <= '0;
            tag_load_reg     <= '0;
            for (int k = 0; k < DEPTH; k++)
                tag_dest_reg[k] <= '0;
            stall_cnt_reg    <= '0;
        end else begin
            tag_valid_reg    <= {tag_valid_reg[DEPTH-2:0], entry_load};
            tag_regwrite_reg <= {tag_regwrite_reg[DEPTH-2:0], id_regwrite};
            tag_load_reg     <= {tag_load_reg[DEPTH-2:0], id_is_load};
            tag_dest_reg[0]  <= id_dest;
            for (int k = 1; k < DEPTH; k++)
                tag_dest_reg[k] <= tag_dest_reg[k-1];
            stall_cnt_reg    <= stall_cnt_next;
        end
    end

endmodule
